// File: rtl/shift_seq_ctrl.sv
// Sequences a multi-bit logical shift through an external 1-bit shift unit.
// Issues one shift per pass, waits for the unit's flag, and pulses Done at the end.
module shift_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] Operand,
  input  logic [CNT_W-1:0] Amount,
  input  logic             Dir,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Shift_Enable,
  output logic [1:0]       Shift_FUN,
  output logic [WIDTH-1:0] Shift_A,
  input  logic [WIDTH-1:0] Shift_OUT,
  input  logic             Shift_Flag
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_work;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_result;
  logic             w_last;

  // ISSUE is only entered with a non-zero count, so the decrement in WAIT cannot wrap.
  assign w_last = (r_cnt == CNT_W'(1));

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_next = (Amount == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (Shift_Flag) begin
          w_next = w_last ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      r_work   <= '0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_work <= Operand;
            r_cnt  <= Amount;
            r_dir  <= Dir;
          end
        end
        S_WAIT: begin
          if (Shift_Flag) begin
            r_work <= Shift_OUT;
            r_cnt  <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE:  r_result <= r_work;
        default: ;
      endcase
    end
  end

  // The work register is stable across ISSUE/WAIT, so it can feed the shift unit directly.
  assign Busy         = (r_state != S_IDLE);
  assign Done         = (r_state == S_DONE);
  assign Shift_Enable = (r_state == S_ISSUE);
  assign Shift_FUN    = {1'b0, r_dir};
  assign Shift_A      = r_work;
  assign Result       = r_result;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural shift unit of configurable delay.
module tb_shift_seq_ctrl;

  logic        Clk;
  logic        RST;
  logic        Start;
  logic [15:0] Operand;
  logic [3:0]  Amount;
  logic        Dir;
  logic        Busy;
  logic        Done;
  logic [15:0] Result;
  logic        Shift_Enable;
  logic [1:0]  Shift_FUN;
  logic [15:0] Shift_A;
  logic [15:0] Shift_OUT;
  logic        Shift_Flag;

  int          total = 0;
  int          bad = 0;
  int          extra = 0;
  logic        spur_flag = 1'b0;
  logic        m_flag;
  int          m_cnt;
  logic [15:0] m_val;

  shift_seq_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
    .Clk(Clk), .RST(RST), .Start(Start), .Operand(Operand), .Amount(Amount),
    .Dir(Dir), .Busy(Busy), .Done(Done), .Result(Result),
    .Shift_Enable(Shift_Enable), .Shift_FUN(Shift_FUN), .Shift_A(Shift_A),
    .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Shift unit: registered result, flag arrives 1 + extra cycles after enable.
  assign Shift_OUT  = m_val;
  assign Shift_Flag = m_flag | spur_flag;

  always @(posedge Clk or posedge RST) begin
    if (RST) begin
      m_flag <= 1'b0;
      m_cnt  <= 0;
      m_val  <= 16'h0;
    end else if (Shift_Enable) begin
      m_val <= (Shift_FUN == 2'b01) ? (Shift_A << 1) : (Shift_A >> 1);
      if (extra == 0) begin
        m_flag <= 1'b1;
      end else begin
        m_flag <= 1'b0;
        m_cnt  <= extra;
      end
    end else begin
      m_flag <= (m_cnt == 1);
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
    end
  end

  // Runs one job and gathers observations; s2 > 1 injects a second Start in that cycle.
  task automatic run_job(input logic [15:0] op, input logic [3:0] amt, input logic d,
                         input int s2, output int done_cyc, output int pulses,
                         output int a_bad, output int fun_bad, output int consec,
                         output int busy_cyc, output int done_cnt, output logic [15:0] res);
    logic [15:0] exp_a;
    logic        prev_en;
    done_cyc = -1; pulses = 0; a_bad = 0; fun_bad = 0; consec = 0;
    busy_cyc = 0; done_cnt = 0; res = 16'h0; exp_a = op; prev_en = 1'b0;
    @(negedge Clk);
    Start = 1'b1; Operand = op; Amount = amt; Dir = d;
    for (int c = 1; c <= 400; c++) begin
      @(negedge Clk);
      if (Shift_Enable) begin
        pulses++;
        if (Shift_A !== exp_a) a_bad++;
        exp_a = d ? (exp_a << 1) : (exp_a >> 1);
        if (prev_en) consec++;
      end
      prev_en = Shift_Enable;
      if (Busy && (Shift_FUN !== {1'b0, d})) fun_bad++;
      if (Busy) busy_cyc++;
      if (Done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc > 0 && c == done_cyc + 1) res = Result;
      if (c == 1) begin
        Start = 1'b0; Operand = 16'h5A5A; Amount = 4'd9; Dir = ~d;
      end
      if (c == s2) begin
        Start = 1'b1; Operand = 16'hAAAA; Amount = 4'd7;
      end
      if (s2 > 1 && c == s2 + 1) Start = 1'b0;
      if (done_cyc > 0 && c >= done_cyc + 3) break;
    end
    Start = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge Clk);
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", Done); end
    total++; if (Shift_Enable !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", Shift_Enable); end
    total++; if (Result !== 16'h0) begin bad++; $display("FAIL reset_result got=%h want=0000", Result); end
    total++; if (Shift_A !== 16'h0) begin bad++; $display("FAIL reset_a got=%h want=0000", Shift_A); end
    total++; if (Shift_FUN !== 2'b00) begin bad++; $display("FAIL reset_fun got=%b want=00", Shift_FUN); end
    RST = 1'b0;
  endtask

  task automatic test_left3;
    int dc, p, ab, fb, cs, bc, dn; logic [15:0] r;
    run_job(16'h8001, 4'd3, 1'b1, 0, dc, p, ab, fb, cs, bc, dn, r);
    total++; if (r !== 16'h0008) begin bad++; $display("FAIL left3_result got=%h want=0008", r); end
    total++; if (dc !== 7) begin bad++; $display("FAIL left3_done_cycle got=%0d want=7", dc); end
    total++; if (p !== 3) begin bad++; $display("FAIL left3_pulses got=%0d want=3", p); end
    total++; if (fb !== 0) begin bad++; $display("FAIL left3_fun got=%0d bad cycles want=0", fb); end
    total++; if (ab !== 0) begin bad++; $display("FAIL left3_shift_a got=%0d bad pulses want=0", ab); end
    total++; if (cs !== 0) begin bad++; $display("FAIL left3_consec got=%0d want=0", cs); end
  endtask

  task automatic test_right4;
    int dc, p, ab, fb, cs, bc, dn; logic [15:0] r;
    run_job(16'hF000, 4'd4, 1'b0, 0, dc, p, ab, fb, cs, bc, dn, r);
    total++; if (r !== 16'h0F00) begin bad++; $display("FAIL right4_result got=%h want=0F00", r); end
    total++; if (dc !== 9) begin bad++; $display("FAIL right4_done_cycle got=%0d want=9", dc); end
    total++; if (bc !== 9) begin bad++; $display("FAIL right4_busy_cycles got=%0d want=9", bc); end
    total++; if (p !== 4) begin bad++; $display("FAIL right4_pulses got=%0d want=4", p); end
    total++; if (fb !== 0) begin bad++; $display("FAIL right4_fun got=%0d bad cycles want=0", fb); end
  endtask

  task automatic test_zero_amount;
    int dc, p, ab, fb, cs, bc, dn; logic [15:0] r;
    run_job(16'h1234, 4'd0, 1'b0, 0, dc, p, ab, fb, cs, bc, dn, r);
    total++; if (r !== 16'h1234) begin bad++; $display("FAIL zero_result got=%h want=1234", r); end
    total++; if (dc !== 1) begin bad++; $display("FAIL zero_done_cycle got=%0d want=1", dc); end
    total++; if (p !== 0) begin bad++; $display("FAIL zero_pulses got=%0d want=0", p); end
    total++; if (bc !== 1) begin bad++; $display("FAIL zero_busy_cycles got=%0d want=1", bc); end
  endtask

  task automatic test_busy_start;
    int dc, p, ab, fb, cs, bc, dn; logic [15:0] r;
    run_job(16'h00FF, 4'd2, 1'b1, 2, dc, p, ab, fb, cs, bc, dn, r);
    total++; if (r !== 16'h03FC) begin bad++; $display("FAIL busy_start_result got=%h want=03FC", r); end
    total++; if (dn !== 1) begin bad++; $display("FAIL busy_start_done_count got=%0d want=1", dn); end
    total++; if (dc !== 5) begin bad++; $display("FAIL busy_start_done_cycle got=%0d want=5", dc); end
    total++; if (p !== 2) begin bad++; $display("FAIL busy_start_pulses got=%0d want=2", p); end
  endtask

  task automatic test_slow_unit;
    int dc, p, ab, fb, cs, bc, dn; logic [15:0] r;
    extra = 3;
    run_job(16'h0003, 4'd2, 1'b1, 0, dc, p, ab, fb, cs, bc, dn, r);
    extra = 0;
    total++; if (r !== 16'h000C) begin bad++; $display("FAIL slow_result got=%h want=000C", r); end
    total++; if (dc !== 11) begin bad++; $display("FAIL slow_done_cycle got=%0d want=11", dc); end
    total++; if (p !== 2) begin bad++; $display("FAIL slow_pulses got=%0d want=2", p); end
  endtask

  task automatic test_max_amount;
    int dc, p, ab, fb, cs, bc, dn; logic [15:0] r;
    run_job(16'hFFFF, 4'd15, 1'b0, 0, dc, p, ab, fb, cs, bc, dn, r);
    total++; if (r !== 16'h0001) begin bad++; $display("FAIL max_right_result got=%h want=0001", r); end
    total++; if (dc !== 31) begin bad++; $display("FAIL max_right_done_cycle got=%0d want=31", dc); end
    total++; if (p !== 15) begin bad++; $display("FAIL max_right_pulses got=%0d want=15", p); end
    total++; if (cs !== 0) begin bad++; $display("FAIL max_right_consec got=%0d want=0", cs); end
    run_job(16'h8001, 4'd15, 1'b1, 0, dc, p, ab, fb, cs, bc, dn, r);
    total++; if (r !== 16'h8000) begin bad++; $display("FAIL max_left_result got=%h want=8000", r); end
    total++; if (ab !== 0) begin bad++; $display("FAIL max_left_shift_a got=%0d bad pulses want=0", ab); end
  endtask

  task automatic test_spurious_flag;
    int busy_seen = 0;
    @(negedge Clk);
    spur_flag = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      if (Busy || Done || Shift_Enable) busy_seen++;
    end
    spur_flag = 1'b0;
    @(negedge Clk);
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL spurious_flag_activity got=%0d want=0", busy_seen); end
    total++; if (Result !== 16'h8000) begin bad++; $display("FAIL spurious_flag_result got=%h want=8000", Result); end
  endtask

  task automatic test_reset_mid;
    int dc, p, ab, fb, cs, bc, dn; logic [15:0] r;
    int done_seen = 0;
    @(negedge Clk);
    Start = 1'b1; Operand = 16'h5555; Amount = 4'd5; Dir = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL reset_mid_busy_before got=%b want=1", Busy); end
    RST = 1'b1;
    #1;
    total++; if ({Busy, Done, Shift_Enable} !== 3'b000) begin bad++; $display("FAIL reset_mid_ctrl got=%b want=000", {Busy, Done, Shift_Enable}); end
    total++; if (Result !== 16'h0) begin bad++; $display("FAIL reset_mid_result got=%h want=0000", Result); end
    total++; if (Shift_A !== 16'h0 || Shift_FUN !== 2'b00) begin bad++; $display("FAIL reset_mid_shift got=%h/%b want=0000/00", Shift_A, Shift_FUN); end
    repeat (2) @(negedge Clk);
    RST = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      if (Done || Busy) done_seen++;
    end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL reset_mid_no_done got=%0d want=0", done_seen); end
    run_job(16'h0001, 4'd1, 1'b1, 0, dc, p, ab, fb, cs, bc, dn, r);
    total++; if (r !== 16'h0002) begin bad++; $display("FAIL after_reset_result got=%h want=0002", r); end
    total++; if (dc !== 3) begin bad++; $display("FAIL after_reset_done_cycle got=%0d want=3", dc); end
  endtask

  initial begin
    RST = 1'b1; Start = 1'b0; Operand = 16'h0; Amount = 4'd0; Dir = 1'b0;
    repeat (2) @(negedge Clk);
    test_reset();
    test_left3();
    test_right4();
    test_zero_amount();
    test_busy_start();
    test_slow_unit();
    test_max_amount();
    test_spurious_flag();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
